// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with registered reads, optional wait states and post-reset clear sweep.
// Ready high means a request is accepted on the coming edge; illegal requests pulse AddrError and touch nothing.
module data_mem_responder #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] Address,
  input  logic        ReadEn,
  input  logic        WriteEn,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrError
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [1:0] S_RST  = CLEAR_ON_RESET ? S_INIT : S_IDLE;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_wait_cnt;
  logic [AW-1:0] r_clr_idx;
  logic [AW-1:0] r_cap_idx;
  logic [31:0]   r_cap_wdat;
  logic          r_cap_wr;
  logic [31:0]   r_rdata;
  logic          r_addr_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [13:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_req;
  logic          w_ready;
  logic          w_illegal;
  logic          w_take;
  logic          w_direct;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_mem_wdat;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_idx;

  assign w_word    = Address[15:2];
  assign w_idx     = w_word[AW-1:0];
  assign w_req     = ReadEn | WriteEn;
  assign w_ready   = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_illegal = (Address[1:0] != 2'b00) ||
                     ({18'd0, w_word} >= 32'(DEPTH_WORDS)) ||
                     (ReadEn && WriteEn);
  assign w_take    = w_ready && w_req && !w_illegal;
  assign w_direct  = (WAIT_STATES == 0) && w_take;

  assign ReadData  = r_rdata;
  assign Ready     = w_ready;
  assign Busy      = (r_state == S_INIT);
  assign AddrError = r_addr_err;

  // Single RAM port shared by the clear sweep, direct accesses and the deferred RESP access.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = r_clr_idx;
    w_mem_wdat = 32'd0;
    w_rd_en    = 1'b0;
    w_rd_idx   = w_idx;
    if (r_state == S_INIT) begin
      w_mem_we = 1'b1;
    end else if (r_state == S_RESP) begin
      w_mem_we   = r_cap_wr;
      w_mem_idx  = r_cap_idx;
      w_mem_wdat = r_cap_wdat;
      w_rd_en    = !r_cap_wr;
      w_rd_idx   = r_cap_idx;
    end else if (w_direct) begin
      w_mem_we   = WriteEn;
      w_mem_idx  = w_idx;
      w_mem_wdat = WriteData;
      w_rd_en    = ReadEn;
    end
  end

  always_ff @(posedge Clock) begin
    if (nReset && w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdat;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state    <= S_RST;
      r_wait_cnt <= 4'd0;
      r_clr_idx  <= '0;
      r_cap_idx  <= '0;
      r_cap_wdat <= 32'd0;
      r_cap_wr   <= 1'b0;
      r_rdata    <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_ready && w_req && w_illegal;
      if (w_rd_en) begin
        r_rdata <= r_mem[w_rd_idx];
      end
      case (r_state)
        S_INIT: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_IDLE, S_RESP: begin
          // RESP keeps Ready high, so it can accept the next request while finishing the current one.
          if ((WAIT_STATES != 0) && w_take) begin
            r_cap_idx  <= w_idx;
            r_cap_wdat <= WriteData;
            r_cap_wr   <= WriteEn;
            r_wait_cnt <= 4'd0;
            r_state    <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: four responder configurations driven by per-scenario tasks and a read-data scoreboard.
module tb_data_mem_responder;
  localparam int N = 4;
  localparam int DEP [N] = '{16, 1024, 16, 16};
  localparam int WS  [N] = '{0, 3, 2, 2};
  localparam bit CLR [N] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       nrst, ren, wen, rdy, busy, aerr;
  logic [N-1:0][15:0] addr;
  logic [N-1:0][31:0] wdat, rdat;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m0 [16];
  logic [31:0] last0;
  logic [31:0] expv;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(DEP[g]), .WAIT_STATES(WS[g]), .CLEAR_ON_RESET(CLR[g])
    ) u_dut (
      .Clock(clk), .nReset(nrst[g]), .Address(addr[g]), .ReadEn(ren[g]),
      .WriteEn(wen[g]), .WriteData(wdat[g]), .ReadData(rdat[g]),
      .Ready(rdy[g]), .Busy(busy[g]), .AddrError(aerr[g])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d, input int budget);
    int n = 0;
    while (!rdy[d] && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (rdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready[%0d] got %b expected 1 within %0d cycles", d, rdy[d], budget);
    end
  endtask

  // Issues one request and returns once its data/commit is complete.
  task automatic access(input int d, input bit wr, input logic [15:0] a, input logic [31:0] v);
    int n = 0;
    ren[d] = !wr; wen[d] = wr; addr[d] = a; wdat[d] = v;
    tick();
    ren[d] = 1'b0; wen[d] = 1'b0;
    if (WS[d] != 0) begin
      while (!rdy[d] && n < 50) begin
        tick();
        n++;
      end
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL access_resp[%0d] ready got %b expected 1", d, rdy[d]);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    int cnt = 0;
    nrst = '0; ren = '0; wen = '0; addr = '0; wdat = '0;
    foreach (m0[i]) m0[i] = 32'd0;
    tick(); tick();
    for (int d = 0; d < N; d++) begin
      checks += 4;
      if (rdat[d] !== 32'd0) begin errors++; $display("FAIL reset_rdat[%0d] got %h expected 0", d, rdat[d]); end
      if (aerr[d] !== 1'b0) begin errors++; $display("FAIL reset_aerr[%0d] got %b expected 0", d, aerr[d]); end
      if (busy[d] !== CLR[d]) begin errors++; $display("FAIL reset_busy[%0d] got %b expected %b", d, busy[d], CLR[d]); end
      if (rdy[d] !== !CLR[d]) begin errors++; $display("FAIL reset_ready[%0d] got %b expected %b", d, rdy[d], !CLR[d]); end
    end
    nrst = '1;
    ren[0] = 1'b1; addr[0] = 16'h003C;
    while (busy[0] && cnt < 100) begin
      cnt++;
      tick();
      checks += 2;
      if (aerr[0] !== 1'b0) begin errors++; $display("FAIL sweep_aerr got %b expected 0", aerr[0]); end
      if (rdat[0] !== 32'd0) begin errors++; $display("FAIL sweep_read_ignored got %h expected 0", rdat[0]); end
    end
    ren[0] = 1'b0;
    checks += 2;
    if (cnt != 16) begin errors++; $display("FAIL sweep_len got %0d expected 16", cnt); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL sweep_ready got %b expected 1", rdy[0]); end
    exp_q.push_back(m0[15]);
    access(0, 1'b0, 16'h003C, 32'd0);
    expv = exp_q.pop_front();
    last0 = expv;
    checks++;
    if (rdat[0] !== expv) begin errors++; $display("FAIL clear_read got %h expected %h", rdat[0], expv); end
  endtask

  task automatic test_n0_write_read;
    wen[0] = 1'b1; addr[0] = 16'h0010; wdat[0] = 32'hDEADBEEF;
    m0[4] = 32'hDEADBEEF;
    tick();
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL n0_ready_w got %b expected 1", rdy[0]); end
    wen[0] = 1'b0; ren[0] = 1'b1;
    exp_q.push_back(m0[4]);
    tick();
    ren[0] = 1'b0;
    expv = exp_q.pop_front();
    last0 = expv;
    checks += 2;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL n0_ready_r got %b expected 1", rdy[0]); end
    if (rdat[0] !== expv) begin errors++; $display("FAIL n0_raw got %h expected %h", rdat[0], expv); end
  endtask

  task automatic test_errors;
    logic [15:0] ea [3] = '{16'h0013, 16'h0000, 16'h0040};
    bit          er [3] = '{1'b1, 1'b1, 1'b0};
    bit          ew [3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      ren[0] = er[k]; wen[0] = ew[k]; addr[0] = ea[k]; wdat[0] = 32'h11111111 * (k + 1);
      tick();
      ren[0] = 1'b0; wen[0] = 1'b0;
      checks += 3;
      if (aerr[0] !== 1'b1) begin errors++; $display("FAIL err_pulse[%0d] got %b expected 1", k, aerr[0]); end
      if (rdat[0] !== last0) begin errors++; $display("FAIL err_rdat[%0d] got %h expected %h", k, rdat[0], last0); end
      if (rdy[0] !== 1'b1) begin errors++; $display("FAIL err_ready[%0d] got %b expected 1", k, rdy[0]); end
      tick();
      checks++;
      if (aerr[0] !== 1'b0) begin errors++; $display("FAIL err_single[%0d] got %b expected 0", k, aerr[0]); end
    end
    exp_q.push_back(m0[0]);
    access(0, 1'b0, 16'h0000, 32'd0);
    expv = exp_q.pop_front();
    last0 = expv;
    checks++;
    if (rdat[0] !== expv) begin errors++; $display("FAIL err_ram_unchanged got %h expected %h", rdat[0], expv); end
  endtask

  task automatic test_wait_states;
    int low = 0;
    wait_ready(1, 2000);
    access(1, 1'b1, 16'h0020, 32'h12345678);
    exp_q.push_back(32'h12345678);
    ren[1] = 1'b1; addr[1] = 16'h0020;
    tick();
    ren[1] = 1'b0;
    while (!rdy[1] && low < 20) begin
      low++;
      wen[1] = (low == 1); addr[1] = 16'h0020; wdat[1] = 32'd0;
      tick();
    end
    wen[1] = 1'b0;
    checks += 2;
    if (low != 3) begin errors++; $display("FAIL ws_ready_low got %0d expected 3", low); end
    if (rdat[1] !== 32'd0) begin errors++; $display("FAIL ws_early_rdat got %h expected 0", rdat[1]); end
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (rdat[1] !== expv) begin errors++; $display("FAIL ws_read got %h expected %h", rdat[1], expv); end
    exp_q.push_back(32'h12345678);
    access(1, 1'b0, 16'h0020, 32'd0);
    expv = exp_q.pop_front();
    checks++;
    if (rdat[1] !== expv) begin errors++; $display("FAIL ws_ignored_write got %h expected %h", rdat[1], expv); end
    wen[1] = 1'b1; addr[1] = 16'h1000; wdat[1] = 32'hBAD0BAD0;
    tick();
    wen[1] = 1'b0;
    checks += 3;
    if (aerr[1] !== 1'b1) begin errors++; $display("FAIL oob_pulse got %b expected 1", aerr[1]); end
    if (rdy[1] !== 1'b1) begin errors++; $display("FAIL oob_ready got %b expected 1", rdy[1]); end
    if (rdat[1] !== 32'h12345678) begin errors++; $display("FAIL oob_rdat got %h expected 12345678", rdat[1]); end
    tick();
    checks++;
    if (aerr[1] !== 1'b0) begin errors++; $display("FAIL oob_single got %b expected 0", aerr[1]); end
    exp_q.push_back(32'd0);
    access(1, 1'b0, 16'h0000, 32'd0);
    expv = exp_q.pop_front();
    checks++;
    if (rdat[1] !== expv) begin errors++; $display("FAIL oob_alias got %h expected %h", rdat[1], expv); end
  endtask

  task automatic test_reset_mid(input int d);
    wait_ready(d, 200);
    access(d, 1'b1, 16'h0008, 32'h5555AAAA);
    exp_q.push_back(32'h5555AAAA);
    access(d, 1'b0, 16'h0008, 32'd0);
    expv = exp_q.pop_front();
    checks++;
    if (rdat[d] !== expv) begin errors++; $display("FAIL mid_prior[%0d] got %h expected %h", d, rdat[d], expv); end
    wen[d] = 1'b1; addr[d] = 16'h0008; wdat[d] = 32'hCAFEF00D;
    tick();
    wen[d] = 1'b0;
    checks++;
    if (rdy[d] !== 1'b0) begin errors++; $display("FAIL mid_in_wait[%0d] got %b expected 0", d, rdy[d]); end
    nrst[d] = 1'b0;
    tick();
    nrst[d] = 1'b1;
    checks += 4;
    if (rdat[d] !== 32'd0) begin errors++; $display("FAIL mid_rdat[%0d] got %h expected 0", d, rdat[d]); end
    if (aerr[d] !== 1'b0) begin errors++; $display("FAIL mid_aerr[%0d] got %b expected 0", d, aerr[d]); end
    if (busy[d] !== CLR[d]) begin errors++; $display("FAIL mid_busy[%0d] got %b expected %b", d, busy[d], CLR[d]); end
    if (rdy[d] !== !CLR[d]) begin errors++; $display("FAIL mid_ready[%0d] got %b expected %b", d, rdy[d], !CLR[d]); end
    wait_ready(d, 200);
    exp_q.push_back(CLR[d] ? 32'd0 : 32'h5555AAAA);
    access(d, 1'b0, 16'h0008, 32'd0);
    expv = exp_q.pop_front();
    checks++;
    if (rdat[d] !== expv) begin errors++; $display("FAIL mid_aborted[%0d] got %h expected %h", d, rdat[d], expv); end
  endtask

  task automatic test_stream;
    int wa = 0;
    int ra;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        wa = int'($urandom_range(15, 0));
        v = $urandom;
        m0[wa] = v;
        ren[0] = 1'b0; wen[0] = 1'b1; addr[0] = 16'(wa * 4); wdat[0] = v;
      end else begin
        ra = ($urandom_range(1, 0) == 1) ? wa : int'($urandom_range(15, 0));
        ren[0] = 1'b1; wen[0] = 1'b0; addr[0] = 16'(ra * 4);
        exp_q.push_back(m0[ra]);
      end
      tick();
      checks++;
      if (aerr[0] !== 1'b0) begin errors++; $display("FAIL stream_aerr[%0d] got %b expected 0", i, aerr[0]); end
      if (i % 2 == 1) begin
        expv = exp_q.pop_front();
        checks++;
        if (rdat[0] !== expv) begin errors++; $display("FAIL stream_read[%0d] got %h expected %h", i, rdat[0], expv); end
      end
    end
    ren[0] = 1'b0; wen[0] = 1'b0;
    tick();
    checks++;
    if (aerr[0] !== 1'b0) begin errors++; $display("FAIL stream_tail_aerr got %b expected 0", aerr[0]); end
  endtask

  initial begin
    test_reset();
    test_n0_write_read();
    test_errors();
    test_wait_states();
    test_reset_mid(2);
    test_reset_mid(3);
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
